instr_fetch_unit: RTL and testbench

- Front end of the single-cycle RISC-V core. Holds the PC and drives the instruction-memory request/response handshake.
- Delivers each fetched 32-bit instruction, with a valid flag, to the control path's INSTRin and to the datapath.
- Consumes the control path's PCSrc and the datapath's branch/jump target to select the next PC.
- Substitutes NOP while the core is not running, and latches a sticky error on a misaligned target or a memory timeout.

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch front end for the single-cycle RISC-V core: owns the PC, runs the
// instruction-memory handshake and presents one instruction at a time to the core.
//
// state  | meaning
// IDLE   | parked, NOP presented, waiting for run
// REQ    | request strobe up at pc, waiting for grant
// WAIT   | granted, waiting for read data (bounded by TIMEOUT)
// HOLD   | fetched instruction presented until the core accepts it
// ERR    | sticky fault (timeout or misaligned target), left only by reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        PCSrc,
  input  logic [31:0] pc_target,
  input  logic        instr_ready,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        imem_ce,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Last WAIT cycle index; reaching it without data is the timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [7:0]  r_cnt;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_accept     = (r_state == S_HOLD) && instr_ready;
  assign w_misaligned = PCSrc && (pc_target[1:0] != 2'b00);
  assign w_next_pc    = PCSrc ? pc_target : w_pc_plus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= 8'd0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          if (run) r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_gnt) begin
            r_cnt   <= 8'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // Data arriving on the final allowed cycle still wins over the timeout.
          if (imem_rvalid) begin
            if (run) begin
              r_instr <= imem_rdata;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= run ? S_REQ : S_IDLE;
            end
          end
        end
        S_ERR: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          r_err   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_ce     = (r_state == S_REQ) || (r_state == S_WAIT);
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the main fetch/branch/stall
// flow plus hand-written sequences for wrap, run/reset control, timeout and misalignment.
module tb_instr_fetch_unit;

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] IA = 32'h0050_0093;
  localparam logic [31:0] IB = 32'h00A0_0113;
  localparam logic [31:0] IC = 32'h0000_0463;
  localparam logic [31:0] ID = 32'h0010_0193;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, PCSrc, instr_ready, imem_gnt, imem_rvalid;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, imem_ce, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr_out, pc_out, pc_plus4;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .PCSrc(PCSrc), .pc_target(pc_target),
    .instr_ready(instr_ready), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ce(imem_ce), .instr_out(instr_out), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, pcsrc;
    logic [31:0] tgt;
    logic        ready, gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req, e_ce, e_valid, e_err;
    logic [31:0] e_addr, e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic run_i, pcsrc_i, input logic [31:0] tgt_i,
                              input logic ready_i, gnt_i, rvalid_i, input logic [31:0] rdata_i,
                              input logic req_e, ce_e, valid_e, err_e,
                              input logic [31:0] addr_e, instr_e);
    vec_t v;
    v.run = run_i; v.pcsrc = pcsrc_i; v.tgt = tgt_i; v.ready = ready_i;
    v.gnt = gnt_i; v.rvalid = rvalid_i; v.rdata = rdata_i;
    v.e_req = req_e; v.e_ce = ce_e; v.e_valid = valid_e; v.e_err = err_e;
    v.e_addr = addr_e; v.e_instr = instr_e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req_e, ce_e, valid_e, err_e,
                         input logic [31:0] addr_e, instr_e);
    chk({tag, " req"},   {31'd0, imem_req},    {31'd0, req_e});
    chk({tag, " ce"},    {31'd0, imem_ce},     {31'd0, ce_e});
    chk({tag, " valid"}, {31'd0, instr_valid}, {31'd0, valid_e});
    chk({tag, " err"},   {31'd0, fetch_err},   {31'd0, err_e});
    chk({tag, " addr"},  imem_addr, addr_e);
    chk({tag, " pc"},    pc_out,    addr_e);
    chk({tag, " pc4"},   pc_plus4,  addr_e + 32'd4);
    chk({tag, " instr"}, instr_out, instr_e);
  endtask

  task automatic drv(input logic run_i, pcsrc_i, input logic [31:0] tgt_i,
                     input logic ready_i, gnt_i, rvalid_i, input logic [31:0] rdata_i);
    run = run_i; PCSrc = pcsrc_i; pc_target = tgt_i; instr_ready = ready_i;
    imem_gnt = gnt_i; imem_rvalid = rvalid_i; imem_rdata = rdata_i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Main flow: fetch, sequential advance, ignored target, branch, slow grant, stall.
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IA, 1,1,0,0,32'h00,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IA, 0,1,0,0,32'h00,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IA, 0,0,1,0,32'h00,IA));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IB, 1,1,0,0,32'h04,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IB, 0,1,0,0,32'h04,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IB, 0,0,1,0,32'h04,IB));
    vecs.push_back(mk(1,0,32'h40,1,1,1,IC, 1,1,0,0,32'h08,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IC, 0,1,0,0,32'h08,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IC, 0,0,1,0,32'h08,IC));
    vecs.push_back(mk(1,1,32'h40,1,0,0,ID, 1,1,0,0,32'h40,N));
    vecs.push_back(mk(1,0,32'h0, 1,0,0,ID, 1,1,0,0,32'h40,N));
    vecs.push_back(mk(1,0,32'h0, 1,0,0,ID, 1,1,0,0,32'h40,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,0,ID, 0,1,0,0,32'h40,N));
    vecs.push_back(mk(1,0,32'h0, 1,1,0,ID, 0,1,0,0,32'h40,N));
    vecs.push_back(mk(1,0,32'h0, 0,1,1,ID, 0,0,1,0,32'h40,ID));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,1,32'h42,0,1,1,IA, 0,0,1,0,32'h40,ID));
    vecs.push_back(mk(1,0,32'h0, 1,1,1,IA, 1,1,0,0,32'h44,N));

    do_reset();
    chk_all("reset", 0,0,0,0, 32'h0, N);

    foreach (vecs[i]) begin
      drv(vecs[i].run, vecs[i].pcsrc, vecs[i].tgt, vecs[i].ready,
          vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_ce, vecs[i].e_valid,
              vecs[i].e_err, vecs[i].e_addr, vecs[i].e_instr);
    end

    // PC wrap: branch to the top word, then sequential advance wraps to zero.
    drv(1,0,32'h0,1,1,1,IA); step(); step();
    chk_all("wrap hold", 0,0,1,0, 32'h44, IA);
    drv(1,1,32'hFFFF_FFFC,1,1,1,IA); step();
    chk_all("wrap top", 1,1,0,0, 32'hFFFF_FFFC, N);
    drv(1,0,32'h0,1,1,1,IB); step(); step(); step();
    chk_all("wrap zero", 1,1,0,0, 32'h0, N);

    // run dropped in WAIT: data discarded, pc kept, same address refetched.
    step(); step(); step();
    chk_all("adv4", 1,1,0,0, 32'h4, N);
    step();
    drv(0,0,32'h0,1,1,0,IC); step();
    chk_all("run0 wait", 0,1,0,0, 32'h4, N);
    drv(0,0,32'h0,1,1,1,IC); step();
    chk_all("run0 rvalid", 0,0,0,0, 32'h4, N);
    step();
    chk_all("run0 idle", 0,0,0,0, 32'h4, N);
    drv(1,0,32'h0,1,1,0,IC); step();
    chk_all("refetch", 1,1,0,0, 32'h4, N);
    step();
    chk_all("refetch wait", 0,1,0,0, 32'h4, N);

    // Asynchronous reset mid-WAIT, then a late rvalid while parked.
    #2 reset = 1'b0;
    #1 chk_all("async rst", 0,0,0,0, 32'h0, N);
    step();
    drv(0,0,32'h0,1,1,1,ID);
    reset = 1'b1;
    step(); step();
    chk_all("late rvalid", 0,0,0,0, 32'h0, N);

    // Timeout: 16 WAIT cycles without data.
    drv(1,0,32'h0,1,1,0,IA); step(); step();
    for (int k = 0; k < 15; k++) step();
    chk_all("wait15", 0,1,0,0, 32'h0, N);
    step();
    chk_all("timeout", 0,0,0,1, 32'h0, N);
    drv(1,0,32'h0,1,1,1,IA);
    for (int k = 0; k < 3; k++) step();
    chk_all("err sticky", 0,0,0,1, 32'h0, N);

    // Data on the 16th WAIT cycle wins over the timeout.
    do_reset();
    drv(1,0,32'h0,1,1,0,IA); step(); step();
    for (int k = 0; k < 15; k++) step();
    drv(1,0,32'h0,0,1,1,IA); step();
    chk_all("rvalid16", 0,0,1,0, 32'h0, IA);

    // Misaligned branch target on accept.
    drv(1,0,32'h0,1,1,1,IB); step(); step(); step();
    chk_all("pre misalign", 0,0,1,0, 32'h4, IB);
    drv(1,1,32'h42,1,1,1,IB); step();
    chk_all("misalign", 0,0,0,1, 32'h4, N);
    step();
    chk_all("misalign sticky", 0,0,0,1, 32'h4, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
